inst_buffer: RTL and testbench
==============================

# inst_buffer

Instruction queue between the fetch stage and the dual decoders. Accepts up to two fetched instructions per cycle, each with PC, predictor result and fetch-stage exception status. Presents the oldest two entries in program order to decode slots 0 and 1. Decouples fetch from decode/issue stalls and discards all contents on pipeline flush.

## Interface

**Parameters**
- `DEPTH`, default 16: number of entries. Must be a power of two, ≥ 4.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all entries (branch mispredict, exception, ertn).
- `in_valid` in 2: fetch slot valid. Slot 0 is older. `in_valid[1]` is ignored unless `in_valid[0]` is set.
- `in_pc` in 2×32: fetch slot PC.
- `in_inst` in 2×32: fetch slot instruction word.
- `in_pre_taken` in 2: predictor taken flag per slot.
- `in_pre_addr` in 2×32: predicted target per slot.
- `in_is_exception` in 2×2: fetch-stage exception flags per slot.
- `in_exception_cause` in 2×2×7: fetch-stage exception causes per slot.
- `in_ready` out 1: queue can take two instructions this cycle.
- `out_valid` out 2: decode slot valid. `out_valid[1]` implies `out_valid[0]`.
- `out_pc`, `out_inst`, `out_pre_taken`, `out_pre_addr`, `out_is_exception`, `out_exception_cause` out: same widths as the `in_*` ports; fields of the head and head+1 entries.
- `out_accept` in 2: decode consumes slot. `out_accept[1]` is ignored unless `out_accept[0]` is set.
- `count` out log2(DEPTH)+1: current occupancy.

## Operation

**Storage**
- Circular array of DEPTH entries. Each entry is 113 bits: pc, inst, pre_taken, pre_addr, is_exception, exception_cause.
- Head pointer `rd_ptr` and tail pointer `wr_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter `count` is kept alongside.

**Enqueue**
- Number of writes `n_enq = in_ready ? (in_valid[0] + (in_valid[0] & in_valid[1])) : 0`.
- Slot 0 is written to `wr_ptr` and slot 1 to `wr_ptr+1`.
- Then `wr_ptr += n_enq`.
- When `in_valid` is set while `in_ready` is low, nothing is written. Fetch must hold its data and retry.

**Ready**
- `in_ready = (DEPTH - count) >= 2`, computed from the registered `count` only.
- Dequeues in the same cycle do not raise `in_ready`. There is no combinational path from `out_accept` to `in_ready`.

**Output**
- `out_valid[0] = (count >= 1) & ~flush`.
- `out_valid[1] = (count >= 2) & ~flush`.
- Slot 0 fields come from entry `rd_ptr` and slot 1 fields from entry `rd_ptr+1`. They are read combinationally from registered storage.
- Entries pass through unmodified. The queue never creates or alters exception bits.

**Dequeue**
- Number of reads `n_deq = (out_valid[0] & out_accept[0]) + (out_valid[1] & out_accept[0] & out_accept[1])`.
- Then `rd_ptr += n_deq`.

**Count update**
- `count_next = count + n_enq - n_deq`.
- Simultaneous enqueue and dequeue are both honoured in the same cycle.

**Flush and reset**
- Flush sets `rd_ptr`, `wr_ptr` and `count` to 0 on the next edge.
- Any same-cycle enqueue or dequeue is discarded.
- Reset behaves identically to flush. Entry storage is not cleared.

## Timing

**Reset values**
- `count` = 0, `out_valid` = 2'b00, `in_ready` = 1.
- Output data fields are don't-care while their valid bit is low.

**Latency**
- An instruction enqueued at edge N is visible on `out_*` in the cycle after edge N.
- There is no bypass from input to output.

**Throughput**
- 2 in and 2 out per cycle in steady state when `count` is between 2 and DEPTH-2.

**Boundary conditions**
- Empty (`count = 0`): `out_valid = 00`; `out_accept` is ignored.
- `count = 1`: only slot 0 valid; `out_accept[1]` is ignored.
- `count = DEPTH-1` or `count = DEPTH`: `in_ready = 0`.
- Pointer wrap past DEPTH-1 preserves program order across the boundary.
- `flush` with `rst` both high: same result as reset.
- `flush` high for consecutive cycles: the queue stays empty and `out_valid = 00` for the whole duration.

## Test plan

1. **Basic pass-through.** After reset, enqueue pc 0x1C000000/0x1C000004 with inst 0x02800C21/0x02801042 -> next cycle `out_valid = 11` with the same pc/inst and `count = 2`.
2. **Fill to full.** DEPTH=16; enqueue 2 per cycle with `out_accept = 00`. After 7 cycles `count = 14` and `in_ready = 1`. After the 8th, `count = 16` and `in_ready = 0`. Further `in_valid` leaves `count` at 16.
3. **Mixed enqueue/dequeue.** At `count = 5`, enqueue 2 with `out_accept = 01` -> `count = 6` and slot 0 advances by one entry. `out_accept = 10` -> nothing is dequeued.
4. **Flush during traffic.** At `count = 9`, assert `flush` together with `in_valid = 11` and `out_accept = 11` -> `out_valid = 00` during the flush cycle; next cycle `count = 0` and `out_valid = 00`. The discarded PCs never appear on `out_*`.
5. **Wrap-around order.** Stream 40 sequential PCs, starting at 0x1C000000 with +4 increments, under random `out_accept` and `in_valid` -> dequeued PCs are strictly sequential with no loss or duplication.
6. **Side-band fields.** Enqueue `is_exception = 2'b01`, cause ADEF, `pre_taken = 1`, `pre_addr = 0x1C000100` -> the identical values appear on the same output slot.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction queue between fetch and the dual decoders: takes up to two
// instructions per cycle and presents the oldest two in program order.
module inst_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [1:0]              in_valid,
  input  logic [63:0]             in_pc,
  input  logic [63:0]             in_inst,
  input  logic [1:0]              in_pre_taken,
  input  logic [63:0]             in_pre_addr,
  input  logic [3:0]              in_is_exception,
  input  logic [27:0]             in_exception_cause,
  output logic                    in_ready,
  output logic [1:0]              out_valid,
  output logic [63:0]             out_pc,
  output logic [63:0]             out_inst,
  output logic [1:0]              out_pre_taken,
  output logic [63:0]             out_pre_addr,
  output logic [3:0]              out_is_exception,
  output logic [27:0]             out_exception_cause,
  input  logic [1:0]              out_accept,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 113;

  // Entry layout: pc[112:81] inst[80:49] pre_taken[48] pre_addr[47:16]
  // is_exception[15:14] exception_cause[13:0]
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr1;
  logic [AW-1:0] wr_ptr1;
  logic [EW-1:0] wdata0;
  logic [EW-1:0] wdata1;
  logic [EW-1:0] rdata0;
  logic [EW-1:0] rdata1;
  logic [1:0]    n_enq;
  logic [1:0]    n_deq;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);

  // Ready looks only at registered occupancy, so same-cycle dequeues never help.
  assign in_ready     = (count <= (AW+1)'(DEPTH - 2));
  assign out_valid[0] = (count != '0) & ~flush;
  assign out_valid[1] = (count >= (AW+1)'(2)) & ~flush;

  assign n_enq = (in_ready & in_valid[0]) ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  assign n_deq = (out_valid[0] & out_accept[0]) ?
                 ((out_valid[1] & out_accept[1]) ? 2'd2 : 2'd1) : 2'd0;

  assign wdata0 = {in_pc[31:0], in_inst[31:0], in_pre_taken[0], in_pre_addr[31:0],
                   in_is_exception[1:0], in_exception_cause[13:0]};
  assign wdata1 = {in_pc[63:32], in_inst[63:32], in_pre_taken[1], in_pre_addr[63:32],
                   in_is_exception[3:2], in_exception_cause[27:14]};

  assign rdata0 = mem[rd_ptr];
  assign rdata1 = mem[rd_ptr1];

  assign out_pc              = {rdata1[112:81], rdata0[112:81]};
  assign out_inst            = {rdata1[80:49],  rdata0[80:49]};
  assign out_pre_taken       = {rdata1[48],     rdata0[48]};
  assign out_pre_addr        = {rdata1[47:16],  rdata0[47:16]};
  assign out_is_exception    = {rdata1[15:14],  rdata0[15:14]};
  assign out_exception_cause = {rdata1[13:0],   rdata0[13:0]};

  // Storage is deliberately not cleared on reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && n_enq != 2'd0) begin
      mem[wr_ptr] <= wdata0;
      if (n_enq == 2'd2) begin
        mem[wr_ptr1] <= wdata1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_enq);
      rd_ptr <= rd_ptr + AW'(n_deq);
      count  <= count + (AW+1)'(n_enq) - (AW+1)'(n_deq);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized bench for inst_buffer: a queue-based model of the entries held,
// compared against the DUT outputs every cycle, plus literal scenario checks.
module tb_inst_buffer;

  localparam int          DEPTH = 16;
  localparam int          W     = 113;
  localparam logic [31:0] BASE  = 32'h1C000000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_pre_taken;
  logic [63:0] in_pre_addr;
  logic [3:0]  in_is_exception;
  logic [27:0] in_exception_cause;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_pre_taken;
  logic [63:0] out_pre_addr;
  logic [3:0]  out_is_exception;
  logic [27:0] out_exception_cause;
  logic [1:0]  out_accept;
  logic [4:0]  count;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr),
    .in_is_exception(in_is_exception), .in_exception_cause(in_exception_cause),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_pre_taken(out_pre_taken),
    .out_pre_addr(out_pre_addr), .out_is_exception(out_is_exception),
    .out_exception_cause(out_exception_cause), .out_accept(out_accept),
    .count(count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         check_en = 1'b0;
  logic         stream_en = 1'b0;
  logic [31:0]  next_pc;
  logic [31:0]  exp_deq_pc;
  int           model_sz;
  int           cmp_sz;
  logic [1:0]   exp_valid;
  logic [1:0]   rnd_v;
  int           remaining;
  logic [W-1:0] dut_slot0;
  logic [W-1:0] dut_slot1;

  function automatic logic [W-1:0] pack(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic pt, input logic [31:0] pa,
                                        input logic [1:0] ex, input logic [13:0] ca);
    return {pc, inst, pt, pa, ex, ca};
  endfunction

  assign dut_slot0 = pack(out_pc[31:0], out_inst[31:0], out_pre_taken[0], out_pre_addr[31:0],
                          out_is_exception[1:0], out_exception_cause[13:0]);
  assign dut_slot1 = pack(out_pc[63:32], out_inst[63:32], out_pre_taken[1], out_pre_addr[63:32],
                          out_is_exception[3:2], out_exception_cause[27:14]);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the queue holds exactly the entries the buffer should hold.
  always @(posedge clk) begin
    model_sz = exp_q.size();
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (model_sz >= 1 && out_accept[0]) begin
        void'(exp_q.pop_front());
        if (model_sz >= 2 && out_accept[1]) void'(exp_q.pop_front());
      end
      if (model_sz <= DEPTH - 2 && in_valid[0]) begin
        exp_q.push_back(pack(in_pc[31:0], in_inst[31:0], in_pre_taken[0], in_pre_addr[31:0],
                             in_is_exception[1:0], in_exception_cause[13:0]));
        if (in_valid[1])
          exp_q.push_back(pack(in_pc[63:32], in_inst[63:32], in_pre_taken[1], in_pre_addr[63:32],
                               in_is_exception[3:2], in_exception_cause[27:14]));
      end
    end
  end

  // Compare process, mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      cmp_sz = exp_q.size();
      exp_valid = {(cmp_sz >= 2) && !flush, (cmp_sz >= 1) && !flush};
      check("count", count, cmp_sz);
      check("in_ready", in_ready, (cmp_sz <= DEPTH - 2));
      check("out_valid", out_valid, exp_valid);
      if (exp_valid[0]) check("slot0", dut_slot0, exp_q[0]);
      if (exp_valid[1]) check("slot1", dut_slot1, exp_q[1]);
      if (stream_en && out_valid[0] && out_accept[0]) begin
        check("stream_pc0", out_pc[31:0], exp_deq_pc);
        exp_deq_pc = exp_deq_pc + 32'd4;
        if (out_valid[1] && out_accept[1]) begin
          check("stream_pc1", out_pc[63:32], exp_deq_pc);
          exp_deq_pc = exp_deq_pc + 32'd4;
        end
      end
    end
  end

  // Driver tasks
  task automatic side_rand();
    in_inst            = {$urandom, $urandom};
    in_pre_taken       = 2'($urandom);
    in_pre_addr        = {$urandom, $urandom};
    in_is_exception    = 4'($urandom);
    in_exception_cause = 28'($urandom);
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] a, input logic fl, input logic r);
    int n;
    in_valid   = v;
    out_accept = a;
    flush      = fl;
    rst        = r;
    in_pc      = {next_pc + 32'd4, next_pc};
    n = (!r && !fl && exp_q.size() <= DEPTH - 2 && v[0]) ? (v[1] ? 2 : 1) : 0;
    @(posedge clk);
    #1;
    next_pc = next_pc + 32'(4 * n);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_accept = 2'b00;
    next_pc = BASE; exp_deq_pc = BASE; in_pc = '0;
    side_rand();
    step(2'b00, 2'b00, 1'b0, 1'b1);
    check_en = 1'b1;
    check("reset_count", count, 5'd0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 2'b00);

    // Basic pass-through
    next_pc = BASE;
    side_rand();
    in_inst = {32'h02801042, 32'h02800C21};
    step(2'b11, 2'b00, 1'b0, 1'b0);
    check("t1_valid", out_valid, 2'b11);
    check("t1_pc", out_pc, {32'h1C000004, 32'h1C000000});
    check("t1_inst", out_inst, {32'h02801042, 32'h02800C21});
    check("t1_count", count, 5'd2);

    // Fill to full
    step(2'b00, 2'b00, 1'b0, 1'b1);
    next_pc = BASE;
    repeat (7) begin side_rand(); step(2'b11, 2'b00, 1'b0, 1'b0); end
    check("t2_count14", count, 5'd14);
    check("t2_ready14", in_ready, 1'b1);
    side_rand(); step(2'b11, 2'b00, 1'b0, 1'b0);
    check("t2_count16", count, 5'd16);
    check("t2_ready16", in_ready, 1'b0);
    side_rand(); step(2'b11, 2'b00, 1'b0, 1'b0);
    check("t2_count_hold", count, 5'd16);

    // Mixed enqueue/dequeue
    step(2'b00, 2'b00, 1'b0, 1'b1);
    next_pc = BASE;
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("t3_count5", count, 5'd5);
    step(2'b11, 2'b01, 1'b0, 1'b0);
    check("t3_count6", count, 5'd6);
    check("t3_head", out_pc[31:0], BASE + 32'd4);
    step(2'b00, 2'b10, 1'b0, 1'b0);
    check("t3_acc10_count", count, 5'd6);
    check("t3_acc10_head", out_pc[31:0], BASE + 32'd4);

    // Flush during traffic
    step(2'b00, 2'b00, 1'b0, 1'b1);
    next_pc = BASE;
    repeat (4) step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("t4_count9", count, 5'd9);
    in_valid = 2'b11; out_accept = 2'b11; flush = 1'b1;
    #1;
    check("t4_flush_valid", out_valid, 2'b00);
    @(posedge clk); #1;
    check("t4_post_count", count, 5'd0);
    step(2'b11, 2'b11, 1'b1, 1'b0);
    step(2'b11, 2'b11, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("t4_after_count", count, 5'd0);
    check("t4_after_valid", out_valid, 2'b00);

    // Reset and flush together
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b1, 1'b1);
    check("rst_flush_count", count, 5'd0);

    // Side-band pass-through (ADEF cause code 0x08)
    next_pc = BASE + 32'h40;
    side_rand();
    in_is_exception = 4'b0001;
    in_exception_cause = 28'h0000008;
    in_pre_taken = 2'b01;
    in_pre_addr[31:0] = 32'h1C000100;
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("t6_valid", out_valid, 2'b01);
    check("t6_pc", out_pc[31:0], BASE + 32'h40);
    check("t6_exc", out_is_exception[1:0], 2'b01);
    check("t6_cause", out_exception_cause[13:0], 14'h0008);
    check("t6_pre_taken", out_pre_taken[0], 1'b1);
    check("t6_pre_addr", out_pre_addr[31:0], 32'h1C000100);

    // Wrap-around order: 40 sequential PCs under random traffic
    step(2'b00, 2'b00, 1'b0, 1'b1);
    next_pc = BASE;
    exp_deq_pc = BASE;
    stream_en = 1'b1;
    for (int i = 0; i < 2000 && next_pc != BASE + 32'd160; i++) begin
      remaining = int'((BASE + 32'd160 - next_pc) >> 2);
      rnd_v = 2'($urandom);
      if (remaining == 1 && rnd_v == 2'b11) rnd_v = 2'b01;
      side_rand();
      step(rnd_v, 2'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(2'b00, 2'b11, 1'b0, 1'b0);
    stream_en = 1'b0;
    check("t5_all_dequeued", exp_deq_pc, BASE + 32'd160);
    check("t5_empty", count, 5'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      side_rand();
      step(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
